// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite list loader and its frame-sync helpers.
package sprite_pkg;
  localparam int N_SPRITES = 20;
  localparam int ENTRY_W   = 24;
  localparam int BUS_W     = 512;

  localparam logic [4:0] ADDR_CTRL   = 5'd20;
  localparam logic [4:0] ADDR_STATUS = 5'd21;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] id;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } loader_state_t;
endpackage

// File: rtl/vblank_edge_detect.sv
// Registers the active-low vertical sync once and pulses on its falling edge.
module vblank_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vs,
  output logic o_vblank_start
);
  logic r_vs_d;

  // Reset low so a sync held low through reset is not mistaken for a new frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_vs_d <= 1'b0;
    else         r_vs_d <= i_vs;
  end

  assign o_vblank_start = r_vs_d & ~i_vs;
endmodule

// File: rtl/sprite_list_loader.sv
// Avalon-MM shadow sprite list, committed atomically to the display stage at vblank start.
module sprite_list_loader
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write,
  input  logic             read,
  input  logic [4:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             vga_vs,
  output logic [BUS_W-1:0] gl_out,
  output logic             gl_write,
  output logic [1:0]       dbg_state
);
  sprite_entry_t   r_shadow [N_SPRITES];
  loader_state_t   r_state;
  loader_state_t   w_state_next;
  logic [15:0]     r_frame_cnt;
  logic [BUS_W-1:0] w_packed;
  logic [31:0]     w_rdata;
  logic            w_wr;
  logic            w_rd;
  logic            w_ctrl_wr;
  logic            w_commit_req;
  logic            w_clear;
  logic            w_vblank_start;
  logic            w_do_commit;
  logic            w_pending;
  logic            w_unused_ok;

  vblank_edge_detect u_vblank (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_vs           (vga_vs),
    .o_vblank_start (w_vblank_start)
  );

  assign w_wr         = chipselect & write;
  assign w_rd         = chipselect & read;
  assign w_ctrl_wr    = w_wr && (address == ADDR_CTRL);
  assign w_commit_req = w_ctrl_wr & writedata[CTRL_COMMIT_BIT];
  assign w_clear      = w_ctrl_wr & writedata[CTRL_CLEAR_BIT];
  assign w_pending    = (r_state == ARMED);
  assign dbg_state    = r_state;
  assign w_unused_ok  = &{1'b0, writedata[31:ENTRY_W]};

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      for (int k = 0; k < N_SPRITES; k++) r_shadow[k] <= '0;
    end else if (w_wr) begin
      for (int k = 0; k < N_SPRITES; k++) begin
        if (address == 5'(k)) r_shadow[k] <= writedata[ENTRY_W-1:0];
      end
    end
  end

  always_comb begin
    w_packed = '0;
    for (int k = 0; k < N_SPRITES; k++) w_packed[k*ENTRY_W +: ENTRY_W] = r_shadow[k];
  end

  // The commit decision is taken in the vblank_start cycle itself, so the captured
  // list is the shadow as it stood at the start of that cycle.
  always_comb begin
    w_state_next = r_state;
    w_do_commit  = 1'b0;
    case (r_state)
      IDLE:   if (w_commit_req) w_state_next = ARMED;
      ARMED: begin
        if (w_vblank_start) begin
          w_state_next = COMMIT;
          w_do_commit  = 1'b1;
        end
      end
      COMMIT: w_state_next = w_commit_req ? ARMED : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      gl_out      <= '0;
      gl_write    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      gl_write <= w_do_commit;
      if (w_do_commit) begin
        gl_out      <= w_packed;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < N_SPRITES; k++) begin
      if (address == 5'(k)) w_rdata = {8'h00, r_shadow[k]};
    end
    if (address == ADDR_STATUS) w_rdata = {r_frame_cnt, 15'h0000, w_pending};
  end

  always_ff @(posedge clk) begin
    if (reset)     readdata <= '0;
    else if (w_rd) readdata <= w_rdata;
  end
endmodule

// File: tb/tb_sprite_list_loader.sv
// Directed bench for sprite_list_loader: transaction-level model plus literal spot checks.
module tb_sprite_list_loader;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         chipselect = 1'b0;
  logic         write = 1'b0;
  logic         read = 1'b0;
  logic [4:0]   address = '0;
  logic [31:0]  writedata = '0;
  logic         vga_vs = 1'b1;
  logic [31:0]  readdata;
  logic [511:0] gl_out;
  logic         gl_write;
  logic [1:0]   dbg_state;

  always #10 clk = ~clk;

  sprite_list_loader dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .vga_vs     (vga_vs),
    .gl_out     (gl_out),
    .gl_write   (gl_write),
    .dbg_state  (dbg_state)
  );

  // Model state: the frame's list as software wrote it, and what the display must see.
  logic [23:0]  m_shadow [20];
  logic [511:0] m_gl;
  logic         m_exp_write;
  logic         m_pending;
  logic [15:0]  m_cnt;
  logic [31:0]  m_rd;
  logic         m_vs_prev;

  int n_tests = 0;
  int n_fail = 0;
  int n_pulses = 0;
  logic chk_en = 1'b0;

  function automatic logic [511:0] pack_model();
    logic [511:0] v;
    v = '0;
    for (int k = 0; k < 20; k++) v[k*24 +: 24] = m_shadow[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 20; k++) m_shadow[k] = '0;
    m_gl = '0; m_exp_write = 1'b0; m_pending = 1'b0;
    m_cnt = '0; m_rd = '0; m_vs_prev = 1'b0;
  endtask

  // One bus cycle; the model is advanced right after the edge it describes.
  task automatic cyc(input logic rst, input logic cs, input logic wr, input logic rd,
                     input logic [4:0] addr, input logic [31:0] wd, input logic vs);
    logic vb;
    logic req;
    @(negedge clk);
    reset = rst; chipselect = cs; write = wr; read = rd;
    address = addr; writedata = wd; vga_vs = vs;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      vb = m_vs_prev & ~vs;
      m_vs_prev = vs;
      if (cs && rd) begin
        if (addr < 5'd20)       m_rd = {8'h00, m_shadow[addr]};
        else if (addr == 5'd21) m_rd = {m_cnt, 15'h0000, m_pending};
        else                    m_rd = 32'h0;
      end
      req = cs && wr && (addr == 5'd20) && wd[0];
      m_exp_write = 1'b0;
      if (vb && m_pending) begin
        m_gl = pack_model();
        m_exp_write = 1'b1;
        m_cnt = m_cnt + 16'd1;
        m_pending = 1'b0;
      end else if (req) begin
        m_pending = 1'b1;
      end
      if (cs && wr) begin
        if (addr < 5'd20) m_shadow[addr] = wd[23:0];
        else if (addr == 5'd20 && wd[1]) for (int k = 0; k < 20; k++) m_shadow[k] = '0;
      end
    end
  endtask

  task automatic idle();               cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); endtask
  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d); cyc(1'b0, 1'b1, 1'b1, 1'b0, a, d, 1'b1); endtask
  task automatic rd_reg(input logic [4:0] a); cyc(1'b0, 1'b1, 1'b0, 1'b1, a, 32'h0, 1'b1); endtask
  task automatic vedge(); cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0); idle(); endtask

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (gl_write !== m_exp_write) begin
        n_fail++;
        $display("FAIL model gl_write @%0t: got %0b want %0b", $time, gl_write, m_exp_write);
      end
      n_tests++;
      if (gl_out !== m_gl) begin
        n_fail++;
        $display("FAIL model gl_out @%0t: got %0h want %0h", $time, gl_out, m_gl);
      end
      n_tests++;
      if (readdata !== m_rd) begin
        n_fail++;
        $display("FAIL model readdata @%0t: got %0h want %0h", $time, readdata, m_rd);
      end
      if (gl_write === 1'b1) n_pulses++;
    end
  end

  initial begin
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("reset gl_out", gl_out, 512'h0);
    chk("reset gl_write", {511'h0, gl_write}, 512'h0);
    chk("reset readdata", {480'h0, readdata}, 512'h0);
    chk_en = 1'b1;
    idle(); idle();

    // Reset while armed drops the request and the shadow.
    wr_reg(5'd0, 32'h0012_3456);
    wr_reg(5'd20, 32'h1);
    rd_reg(5'd21);
    chk("armed pending", {480'h0, readdata}, 512'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    idle();
    vedge();
    chk("reset-armed no strobe", n_pulses, 0);
    rd_reg(5'd21);
    chk("reset-armed status", {480'h0, readdata}, 512'h0);
    chk("reset-armed gl_out", gl_out, 512'h0);
    rd_reg(5'd0);
    chk("reset-armed entry0", {480'h0, readdata}, 512'h0);

    // Basic commit.
    wr_reg(5'd0, 32'h000A_0281);
    wr_reg(5'd19, 32'h00FF_FFF5);
    wr_reg(5'd20, 32'h1);
    idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("basic strobe", {511'h0, gl_write}, 512'h1);
    chk("basic entry0", gl_out[23:0], 512'h0A0281);
    chk("basic entry19", gl_out[479:456], 512'hFFFFF5);
    chk("basic upper", gl_out[511:480], 512'h0);
    idle();
    chk("basic strobe drops", {511'h0, gl_write}, 512'h0);
    rd_reg(5'd21);
    chk("basic status", {480'h0, readdata}, 512'h0001_0000);
    chk("basic pulses", n_pulses, 1);

    // Atomicity: no request, no update.
    wr_reg(5'd3, 32'h0011_1111);
    vedge(); vedge();
    chk("atomic entry3", gl_out[95:72], 512'h0);
    chk("atomic pulses", n_pulses, 1);
    rd_reg(5'd21);
    chk("atomic status", {480'h0, readdata}, 512'h0001_0000);

    // Entry write coincident with vblank_start goes to the next commit.
    wr_reg(5'd5, 32'h0000_0007);
    wr_reg(5'd20, 32'h1);
    idle();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_0042, 1'b0);
    chk("race old entry5", gl_out[143:120], 512'h7);
    idle();
    wr_reg(5'd20, 32'h1);
    vedge();
    chk("race new entry5", gl_out[143:120], 512'h42);
    chk("race entry3", gl_out[95:72], 512'h111111);
    chk("race pulses", n_pulses, 3);

    // Coalescing.
    wr_reg(5'd20, 32'h1); wr_reg(5'd20, 32'h1); wr_reg(5'd20, 32'h1);
    vedge(); vedge();
    chk("coalesce pulses", n_pulses, 4);

    // Frame counter wrap, preloaded instead of 65k real commits.
    force dut.r_frame_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    idle();
    release dut.r_frame_cnt;
    rd_reg(5'd21);
    chk("preload status", {480'h0, readdata}, 512'hFFFF_0000);
    wr_reg(5'd20, 32'h1);
    vedge();
    rd_reg(5'd21);
    chk("wrap status", {480'h0, readdata}, 512'h0);

    // Request in the vblank_start cycle arms only.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd20, 32'h1, 1'b0);
    chk("same-cycle no strobe", {511'h0, gl_write}, 512'h0);
    idle();
    rd_reg(5'd21);
    chk("same-cycle pending", {480'h0, readdata}, 512'h1);
    vedge();
    rd_reg(5'd21);
    chk("same-cycle later commit", {480'h0, readdata}, 512'h0001_0000);
    chk("same-cycle pulses", n_pulses, 6);

    // Readback, ignored bits, unmapped addresses, clear.
    wr_reg(5'd7, 32'h0077_7777);
    rd_reg(5'd7);
    chk("read entry7", {480'h0, readdata}, 512'h0077_7777);
    wr_reg(5'd1, 32'hAB12_3456);
    rd_reg(5'd1);
    chk("read entry1 high byte", {480'h0, readdata}, 512'h0012_3456);
    idle(); idle();
    chk("readdata holds", {480'h0, readdata}, 512'h0012_3456);
    wr_reg(5'd25, 32'hFFFF_FFFF);
    rd_reg(5'd25);
    chk("read addr25", {480'h0, readdata}, 512'h0);
    wr_reg(5'd20, 32'h2);
    rd_reg(5'd7);
    chk("clear entry7", {480'h0, readdata}, 512'h0);
    rd_reg(5'd19);
    chk("clear entry19", {480'h0, readdata}, 512'h0);

    // Clear while armed commits an empty list.
    wr_reg(5'd2, 32'h0022_2222);
    wr_reg(5'd20, 32'h1);
    wr_reg(5'd20, 32'h2);
    vedge();
    chk("clear-armed gl_out", gl_out, 512'h0);
    chk("clear-armed pulses", n_pulses, 7);
    idle(); idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
